// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and widths: MEM-stage state encoding and datapath sizes.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int PC_W   = 22;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } mem_state_t;
endpackage

// File: rtl/wb_data_sel.sv
// Writeback data mux: priority is return PC, then load data, then mov data, then ALU result.
module wb_data_sel
  import cpu_pkg::*;
(
  input  logic              i_pc_sel,
  input  logic              i_mem_sel,
  input  logic              i_mov_sel,
  input  logic [PC_W-1:0]   i_pc_data,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_mov_data,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic [DATA_W-1:0] o_wb_data
);
  always_comb begin
    o_wb_data = i_alu_data;
    if (i_pc_sel)       o_wb_data = {{(DATA_W-PC_W){1'b0}}, i_pc_data};
    else if (i_mem_sel) o_wb_data = i_rdata;
    else if (i_mov_sel) o_wb_data = i_mov_data;
  end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory request at a time, stalls upstream until ack,
// and registers the writeback fields. Optional BUSY timeout under MEM_STAGE_TIMEOUT_EN.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_mem_we,
  input  logic              MEM_wb_mem_sel,
  input  logic              MEM_wb_pc_sel,
  input  logic              MEM_wb_we,
  input  logic              MEM_wb_mov_sel,
  input  logic              MEM_hlt,
  input  logic [REG_W-1:0]  MEM_dst_reg,
  input  logic [DATA_W-1:0] MEM_mov_data,
  input  logic [DATA_W-1:0] MEM_alu_data,
  input  logic [DATA_W-1:0] MEM_sw_data,
  input  logic [PC_W-1:0]   MEM_wb_pc_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              WB_wb_we,
  output logic [REG_W-1:0]  WB_dst_reg,
  output logic [DATA_W-1:0] WB_wb_data,
  output logic              WB_hlt,
  output logic              timeout_err
);
  mem_state_t        r_state;
  logic              r_dmem_req, r_dmem_we;
  logic [DATA_W-1:0] r_dmem_addr, r_dmem_wdata;
  logic              r_wb_we, r_wb_hlt;
  logic [REG_W-1:0]  r_wb_dst;
  logic [DATA_W-1:0] r_wb_data;
  logic              w_mem_op;
  logic [DATA_W-1:0] w_wb_data;

  assign w_mem_op = MEM_mem_we | MEM_wb_mem_sel;

  wb_data_sel u_wb_data_sel (
    .i_pc_sel   (MEM_wb_pc_sel),
    .i_mem_sel  (MEM_wb_mem_sel),
    .i_mov_sel  (MEM_wb_mov_sel),
    .i_pc_data  (MEM_wb_pc_data),
    .i_rdata    (dmem_rdata),
    .i_mov_data (MEM_mov_data),
    .i_alu_data (MEM_alu_data),
    .o_wb_data  (w_wb_data)
  );

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        r_timeout_err;
  assign timeout_err = r_timeout_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_wb_we      <= 1'b0;
      r_wb_hlt     <= 1'b0;
      r_wb_dst     <= '0;
      r_wb_data    <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            r_state      <= BUSY;
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= MEM_mem_we;
            r_dmem_addr  <= MEM_alu_data;
            r_dmem_wdata <= MEM_sw_data;
            r_wb_we      <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
          end else if (MEM_hlt) begin
            r_state  <= HALTED;
            r_wb_hlt <= 1'b1;
            r_wb_we  <= 1'b0;
          end else begin
            r_wb_we   <= MEM_wb_we;
            r_wb_dst  <= MEM_dst_reg;
            r_wb_data <= w_wb_data;
            r_wb_hlt  <= MEM_hlt;
          end
        end
        BUSY: begin
          // EX/MEM is held while stalled, so MEM_* still describe this instruction at ack
          if (dmem_ack) begin
            r_state    <= IDLE;
            r_dmem_req <= 1'b0;
            r_wb_we    <= MEM_wb_we;
            r_wb_dst   <= MEM_dst_reg;
            r_wb_data  <= w_wb_data;
            r_wb_hlt   <= MEM_hlt;
`ifdef MEM_STAGE_TIMEOUT_EN
          end else if (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            r_state       <= IDLE;
            r_dmem_req    <= 1'b0;
            r_wb_we       <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
`endif
          end
        end
        HALTED: ;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_stall  = ((r_state == IDLE) & w_mem_op) | ((r_state == BUSY) & ~dmem_ack) |
                      (r_state == HALTED);
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign WB_wb_we   = r_wb_we;
  assign WB_dst_reg = r_wb_dst;
  assign WB_wb_data = r_wb_data;
  assign WB_hlt     = r_wb_hlt;
endmodule
